// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, sync polarity and frame-buffer sizing helpers.
// Used by the scanout, frame_buffer, graphics_fsm and the benches.
package vga_pkg;

    localparam int HOR_ACTIVE_PIXELS = 640;
    localparam int HOR_FRONT_PORCH   = 16;
    localparam int HOR_SYNC_PULSE    = 96;
    localparam int HOR_BACK_PORCH    = 48;
    localparam int VER_ACTIVE_PIXELS = 480;
    localparam int VER_FRONT_PORCH   = 10;
    localparam int VER_SYNC_PULSE    = 2;
    localparam int VER_BACK_PORCH    = 33;

    localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
    localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;

    // Both syncs are active low for this mode.
    localparam logic SYNC_ASSERTED = 1'b0;
    localparam logic SYNC_IDLE     = 1'b1;

    function automatic int pixels_count_for(input int hor, input int ver);
        return hor * ver;
    endfunction

    function automatic int addr_width_for(input int hor, input int ver);
        return $clog2(hor * ver);
    endfunction

    localparam int PIXELS_COUNT = pixels_count_for(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    localparam int ADDR_WIDTH   = addr_width_for(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);

    function automatic logic sync_level(input logic in_pulse);
        return in_pulse ? SYNC_ASSERTED : SYNC_IDLE;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port, swap strobe and VGA pins of the scanout.
// test_pattern exists only when VGA_SCANOUT_TEST_PATTERN_EN is defined.
interface vga_scanout_if #(
    parameter int ADDR_WIDTH = vga_pkg::ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_data;
    logic                  swap;
    logic                  vga_hsync;
    logic                  vga_vsync;
    logic                  vga_pixel;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic                  test_pattern;

    modport master (
        output read_addr, swap, vga_hsync, vga_vsync, vga_pixel,
        input  read_data, test_pattern
    );
    modport slave (
        input  read_addr, swap, vga_hsync, vga_vsync, vga_pixel,
        output read_data, test_pattern
    );
`else
    modport master (
        output read_addr, swap, vga_hsync, vga_vsync, vga_pixel,
        input  read_data
    );
    modport slave (
        input  read_addr, swap, vga_hsync, vga_vsync, vga_pixel,
        output read_data
    );
`endif
endinterface

// File: rtl/vga_timing_counter.sv
// Raster position counters with active-area, raw sync and frame/blank strobes decoded
// from the current (h,v); all decodes belong to the same cycle as h and v.
module vga_timing_counter #(
    parameter int HOR_ACTIVE_PIXELS = vga_pkg::HOR_ACTIVE_PIXELS,
    parameter int HOR_FRONT_PORCH   = vga_pkg::HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PULSE    = vga_pkg::HOR_SYNC_PULSE,
    parameter int HOR_BACK_PORCH    = vga_pkg::HOR_BACK_PORCH,
    parameter int VER_ACTIVE_PIXELS = vga_pkg::VER_ACTIVE_PIXELS,
    parameter int VER_FRONT_PORCH   = vga_pkg::VER_FRONT_PORCH,
    parameter int VER_SYNC_PULSE    = vga_pkg::VER_SYNC_PULSE,
    parameter int VER_BACK_PORCH    = vga_pkg::VER_BACK_PORCH,
    parameter int H_WIDTH = $clog2(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH),
    parameter int V_WIDTH = $clog2(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH)
)(
    input  logic               clk,
    input  logic               rst,
    output logic [H_WIDTH-1:0] h,
    output logic [V_WIDTH-1:0] v,
    output logic               active,
    output logic               hsync_raw,
    output logic               vsync_raw,
    output logic               frame_start,
    output logic               blank_start
);
    import vga_pkg::*;

    localparam int H_PERIOD = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
    localparam int V_PERIOD = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
    localparam int HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int HS_END   = HS_START + HOR_SYNC_PULSE;
    localparam int VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int VS_END   = VS_START + VER_SYNC_PULSE;

    logic [H_WIDTH-1:0] h_r;
    logic [V_WIDTH-1:0] v_r;

    // Raster position: h advances every cycle, v advances on each line wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r <= '0;
            v_r <= '0;
        end else if (h_r == H_WIDTH'(H_PERIOD - 1)) begin
            h_r <= '0;
            if (v_r == V_WIDTH'(V_PERIOD - 1)) begin
                v_r <= '0;
            end else begin
                v_r <= v_r + V_WIDTH'(1);
            end
        end else begin
            h_r <= h_r + H_WIDTH'(1);
        end
    end

    // Decode the current position into area, sync and strobe flags.
    always_comb begin
        active      = (h_r < H_WIDTH'(HOR_ACTIVE_PIXELS)) && (v_r < V_WIDTH'(VER_ACTIVE_PIXELS));
        hsync_raw   = sync_level((h_r >= H_WIDTH'(HS_START)) && (h_r < H_WIDTH'(HS_END)));
        vsync_raw   = sync_level((v_r >= V_WIDTH'(VS_START)) && (v_r < V_WIDTH'(VS_END)));
        frame_start = (h_r == '0) && (v_r == '0);
        blank_start = (h_r == '0) && (v_r == V_WIDTH'(VER_ACTIVE_PIXELS));
    end

    assign h = h_r;
    assign v = v_r;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: frame-buffer address stream, swap strobe, sync and pixel pins, 2 cycles behind the raster.
// Optional VGA_SCANOUT_TEST_PATTERN_EN adds test_pattern, selecting an 8x8 checkerboard instead of read_data.
module vga_scanout #(
    parameter int HOR_ACTIVE_PIXELS = vga_pkg::HOR_ACTIVE_PIXELS,
    parameter int HOR_FRONT_PORCH   = vga_pkg::HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PULSE    = vga_pkg::HOR_SYNC_PULSE,
    parameter int HOR_BACK_PORCH    = vga_pkg::HOR_BACK_PORCH,
    parameter int VER_ACTIVE_PIXELS = vga_pkg::VER_ACTIVE_PIXELS,
    parameter int VER_FRONT_PORCH   = vga_pkg::VER_FRONT_PORCH,
    parameter int VER_SYNC_PULSE    = vga_pkg::VER_SYNC_PULSE,
    parameter int VER_BACK_PORCH    = vga_pkg::VER_BACK_PORCH
)(
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master vga
);
    import vga_pkg::*;

    localparam int H_PERIOD  = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
    localparam int V_PERIOD  = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
    localparam int PIX_TOTAL = pixels_count_for(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    localparam int AW        = addr_width_for(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    localparam int H_WIDTH   = $clog2(H_PERIOD);
    localparam int V_WIDTH   = $clog2(V_PERIOD);

    logic [H_WIDTH-1:0] h_s;
    logic [V_WIDTH-1:0] v_s;
    logic               active_s;
    logic               hsync_raw_s;
    logic               vsync_raw_s;
    logic               frame_start_s;
    logic               blank_start_s;
    logic               last_pixel_s;
    logic [AW-1:0]      addr_cnt_r;
    logic [AW-1:0]      addr_cur_s;
    logic [AW-1:0]      addr_next_s;
    logic [AW-1:0]      read_addr_r;
    logic               swap_r;
    logic               active_d1_r;
    logic               active_d2_r;
    logic               hsync_d1_r;
    logic               hsync_d2_r;
    logic               vsync_d1_r;
    logic               vsync_d2_r;
    logic               pixel_s;

    vga_timing_counter #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
        .HOR_SYNC_PULSE    (HOR_SYNC_PULSE),
        .HOR_BACK_PORCH    (HOR_BACK_PORCH),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .VER_FRONT_PORCH   (VER_FRONT_PORCH),
        .VER_SYNC_PULSE    (VER_SYNC_PULSE),
        .VER_BACK_PORCH    (VER_BACK_PORCH),
        .H_WIDTH           (H_WIDTH),
        .V_WIDTH           (V_WIDTH)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h           (h_s),
        .v           (v_s),
        .active      (active_s),
        .hsync_raw   (hsync_raw_s),
        .vsync_raw   (vsync_raw_s),
        .frame_start (frame_start_s),
        .blank_start (blank_start_s)
    );

    // Address of the current position: forced to 0 at frame top, saturates on the last visible pixel.
    always_comb begin
        last_pixel_s = (h_s == H_WIDTH'(HOR_ACTIVE_PIXELS - 1)) && (v_s == V_WIDTH'(VER_ACTIVE_PIXELS - 1));
        if (frame_start_s) begin
            addr_cur_s = '0;
        end else begin
            addr_cur_s = addr_cnt_r;
        end
        if (active_s && !last_pixel_s) begin
            addr_next_s = addr_cur_s + AW'(1);
        end else begin
            addr_next_s = addr_cur_s;
        end
    end

    // Address counter, stage-1 read address, swap strobe and the 2-deep alignment pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt_r  <= '0;
            read_addr_r <= '0;
            swap_r      <= 1'b0;
            active_d1_r <= 1'b0;
            active_d2_r <= 1'b0;
            hsync_d1_r  <= SYNC_IDLE;
            hsync_d2_r  <= SYNC_IDLE;
            vsync_d1_r  <= SYNC_IDLE;
            vsync_d2_r  <= SYNC_IDLE;
        end else begin
            addr_cnt_r  <= addr_next_s;
            read_addr_r <= addr_cur_s;
            swap_r      <= blank_start_s;
            active_d1_r <= active_s;
            active_d2_r <= active_d1_r;
            hsync_d1_r  <= hsync_raw_s;
            hsync_d2_r  <= hsync_d1_r;
            vsync_d1_r  <= vsync_raw_s;
            vsync_d2_r  <= vsync_d1_r;
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic h3_d1_r;
    logic h3_d2_r;
    logic v3_d1_r;
    logic v3_d2_r;

    // Checkerboard select bits travel with the rest of the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            h3_d1_r <= 1'b0;
            h3_d2_r <= 1'b0;
            v3_d1_r <= 1'b0;
            v3_d2_r <= 1'b0;
        end else begin
            h3_d1_r <= h_s[3];
            h3_d2_r <= h3_d1_r;
            v3_d1_r <= v_s[3];
            v3_d2_r <= v3_d1_r;
        end
    end

    // Pixel gate: read_data arrives here directly, so the pin has no further register.
    always_comb begin
        if (vga.test_pattern) begin
            pixel_s = active_d2_r & (h3_d2_r ^ v3_d2_r);
        end else begin
            pixel_s = vga.read_data & active_d2_r;
        end
    end
`else
    // Pixel gate: read_data arrives here directly, so the pin has no further register.
    always_comb begin
        pixel_s = vga.read_data & active_d2_r;
    end
`endif

    assign vga.read_addr = read_addr_r;
    assign vga.swap      = swap_r;
    assign vga.vga_hsync = hsync_d2_r;
    assign vga.vga_vsync = vsync_d2_r;
    assign vga.vga_pixel = pixel_s;

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of frame_buffer.
- Generates 640x480@60 VGA timing from the 25.175 MHz pixel clock and streams frame_buffer read_data to a 1-bit monochrome pixel output.
- Issues the once-per-frame swap pulse that flips frame_buffer halves, so graphics_fsm always draws into the hidden half.
- Replaces the bench-driven frame_buffer_read_addr/swap in the full top.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line
- HOR_FRONT_PORCH, 16, pixels
- HOR_SYNC_PULSE, 96, pixels
- HOR_BACK_PORCH, 48, pixels
- VER_ACTIVE_PIXELS, 480, visible lines per frame
- VER_FRONT_PORCH, 10, lines
- VER_SYNC_PULSE, 2, lines
- VER_BACK_PORCH, 33, lines

Derived localparams: H_TOTAL=800, V_TOTAL=525, PIXELS_COUNT=307200, ADDR_WIDTH=clog2(PIXELS_COUNT)=19.

Ports:
- clk  in  1  pixel clock, 25.175 MHz
- rst  in  1  synchronous, active-high reset
- read_addr  out  ADDR_WIDTH  frame_buffer read address
- read_data  in  1  frame_buffer read data; valid 1 cycle after read_addr
- swap  out  1  1-cycle pulse to frame_buffer and graphics_fsm
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_pixel  out  1  pixel value, forced 0 outside active area

Behaviour:
- One clock domain (clk). rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - h=0, v=0, address counter=0
  - read_addr=0, swap=0, vga_hsync=1, vga_vsync=1, vga_pixel=0
  - delay pipeline cleared to the inactive values above
- Reset mid-frame: all of the above take effect on the next edge. The first cycle after rst falls is position (0,0).
- Stage 0 counters:
  - h increments every cycle and wraps from H_TOTAL-1 to 0.
  - v increments when h wraps, and wraps from V_TOTAL-1 to 0.
  - active = (h < HOR_ACTIVE_PIXELS) && (v < VER_ACTIVE_PIXELS).
- Address counter (no multiplier):
  - Cleared when the counters are at (0,0).
  - Incremented by 1 on each active cycle; held during blanking.
  - Maximum value 307199; never overflows.
- Stage 1:
  - read_addr is registered from the address counter for position (h,v).
  - It becomes visible on the cycle after (h,v).
- Stage 2:
  - read_data for that address is valid.
  - vga_pixel = read_data & active_d2.
- Sync signals:
  - hsync_raw is low for h in [656,751]; vsync_raw is low for v in [490,491].
  - Both are delayed 2 cycles (with active) so they stay aligned with vga_pixel.
- Total latency: counter position to pins = 2 cycles, uniform across all outputs.
- swap:
  - Single-cycle pulse on the cycle after the counters reach (h=0, v=VER_ACTIVE_PIXELS), i.e. at the start of vertical blanking.
  - Exactly one pulse per V_TOTAL*H_TOTAL = 420000 cycles.
  - Never asserted during the active area.
- No handshake on read_data. frame_buffer's 1-cycle read latency is a fixed contract.

Optional Feature:
- Macro VGA_SCANOUT_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_pattern (1 bit).
  - When test_pattern=1, vga_pixel = active_d2 & (h_d2[3] ^ v_d2[3]), an 8x8 checkerboard; read_data is ignored.
  - read_addr and swap are unaffected.
  - test_pattern is sampled at stage 2 with no extra latency.
- Undefined: the port and the pattern logic are absent; behaviour is as described above.

Decomposition:
- Package vga_pkg:
  - 640x480 timing constants: porches, sync widths, H_TOTAL, V_TOTAL.
  - Sync-polarity constants.
  - ADDR_WIDTH/PIXELS_COUNT helpers.
  - Shared with frame_buffer, graphics_fsm and the benches.
- Sub-module vga_timing_counter:
  - Outputs h, v, active, hsync_raw, vsync_raw.
  - Also outputs frame_start and blank_start strobes.
- vga_scanout adds the address counter, the 2-stage alignment pipeline, swap and the pixel gate.

Test Plan:
- Reset, then free-run 1 frame -> vga_hsync low for cycles 658..753 of each line. Line starts at cycle 0 after reset; 96-cycle width, 800-cycle period.
- Free-run 2 frames -> vga_vsync low for lines 490..491 (1600 cycles), aligned 2 cycles late. swap pulses exactly once per frame, at cycles 384001 and 804001; each pulse is 1 cycle wide.
- Monitor read_addr:
  - Line 0 sequence is 0..639.
  - Line 1 starts at 640.
  - Last active value is 307199.
  - Value is held through blanking, then returns to 0 at the next frame.
- Model frame_buffer with read_data = addr[0] at 1-cycle latency -> vga_pixel alternates 0,1,... across active pixels, is 0 in blanking, and its first 1 appears at cycle 3.
- Assert rst at h=300, v=200 for 1 cycle -> next cycle all outputs at reset values. After release, the hsync edge is at cycle 658 and the swap pulse at cycle 384001 relative to rst fall.
- With VGA_SCANOUT_TEST_PATTERN_EN and test_pattern=1, read_data=0 -> checkerboard: pixel (8,0)=1 and (8,8)=0, swap timing unchanged.
